// File: rtl/tybec_stream_pkg.sv
// rtl/tybec_stream_pkg.sv - shared types and helpers for the kernel output stream buffer
package tybec_stream_pkg;

    localparam int STREAMW_DEFAULT = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } st_t;

    // Ceiling log2 usable in parameter expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tybec_sync_fifo.sv
// rtl/tybec_sync_fifo.sv - first-word fall-through synchronous FIFO with occupancy count
module tybec_sync_fifo
    import tybec_stream_pkg::*;
#(
    parameter int STREAMW = STREAMW_DEFAULT,
    parameter int DEPTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [STREAMW-1:0]      wdata,
    input  logic                    pop,
    output logic [STREAMW-1:0]      rdata,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   fill
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [STREAMW-1:0] mem [DEPTH];
    logic [PW-1:0]      wp;
    logic [PW-1:0]      rp;
    logic               wr_en;
    logic               rd_en;

    // Overflow/underflow attempts are dropped here so the pointers can never cross.
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    // Pointer update; the extra MSB toggles on every lap so full and empty differ.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en) wp <= wp + 1'b1;
            if (rd_en) rp <= rp + 1'b1;
        end
    end

    // Storage write; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wp[AW-1:0]] <= wdata;
        end
    end

    assign empty = (wp == rp);
    assign full  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
    assign fill  = wp - rp;
    assign rdata = mem[rp[AW-1:0]];

endmodule

// File: rtl/kernel_out_buffer.sv
// rtl/kernel_out_buffer.sv - kernel output decoupling buffer with element counting and done flag
module kernel_out_buffer
    import tybec_stream_pkg::*;
#(
    parameter int STREAMW = STREAMW_DEFAULT,
    parameter int DEPTH   = 8,
    parameter int NELEM   = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ivalid,
    output logic                    iready,
    input  logic [STREAMW-1:0]      kd_vin_s0,
    output logic                    ovalid,
    input  logic                    oready,
    output logic [STREAMW-1:0]      kd_vout_s0,
    output logic [clog2(DEPTH):0]   fill,
    output logic                    done
);

    localparam int             CW      = clog2(NELEM + 1);
    localparam logic [CW-1:0]  NELEM_C = CW'(NELEM);

    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          in_open;
    logic          last_push;
    logic          last_pop;
    logic          done_q;
    st_t           st;
    st_t           st_nxt;

    // Once NELEM words are in, the kernel is cut off so overrun never reaches memory.
    assign in_open   = (in_cnt != NELEM_C);
    assign iready    = ~rst & ~full & in_open;
    assign ovalid    = ~empty;
    assign push      = ivalid & iready;
    assign pop       = ovalid & oready;
    assign last_push = push && (in_cnt == NELEM_C - 1'b1);
    assign last_pop  = pop && (out_cnt == NELEM_C - 1'b1);
    assign done      = done_q;

    tybec_sync_fifo #(
        .STREAMW (STREAMW),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (kd_vin_s0),
        .pop   (pop),
        .rdata (kd_vout_s0),
        .full  (full),
        .empty (empty),
        .fill  (fill)
    );

    // Push and pop counters; both stop at NELEM.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (push) in_cnt <= in_cnt + 1'b1;
            if (pop && (out_cnt != NELEM_C)) out_cnt <= out_cnt + 1'b1;
        end
    end

    // Run-phase state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= RUN;
        end else begin
            st <= st_nxt;
        end
    end

    // Next state: the last push closes the input, the last pop finishes the run.
    always_comb begin
        st_nxt = st;
        case (st)
            RUN:     if (last_push) st_nxt = DRAIN;
            DRAIN:   if (last_pop)  st_nxt = DONE;
            DONE:    st_nxt = DONE;
            default: st_nxt = RUN;
        endcase
    end

    // Sticky completion flag, visible the cycle after the final pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else if (last_pop) begin
            done_q <= 1'b1;
        end
    end

endmodule
